// File: rtl/mdio_pkg.sv
// Shared clause-22 MDIO definitions: frame codes, field widths and the
// target-side frame state encoding.
package mdio_pkg;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] ST_CODE  = 2'b01;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ST1   = 3'd1,
      S_OP    = 3'd2,
      S_PHYAD = 3'd3,
      S_REGAD = 3'd4,
      S_TA    = 3'd5,
      S_DATA  = 3'd6
   } mdio_state_e;

   // Only the read and write opcodes describe a frame this target will serve.
   function automatic logic op_is_valid(input logic [1:0] op);
      return (op == OP_READ) || (op == OP_WRITE);
   endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level plus a one-clock pulse on
// each synchronized 0->1 transition.
module mdio_edge_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Shift the raw input through the synchronizer and remember the last
   // synchronized level. Resetting to the high level prevents a false edge
   // right after reset when the input already sits high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mdio_slave_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO on the system clock, decodes
// preamble/ST/OP/PHYAD/REGAD, issues local register read/write strobes and
// drives turnaround and read data back onto the shared MDIO line.
// SYNC_STAGES must be at least 2.
module mdio_slave_responder
   import mdio_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PHY_ADDR     = 5'h11,
   parameter int                PREAMBLE_MIN = 32,
   parameter int                SYNC_STAGES  = 2
) (
   input  logic              ip_master_clk,
   input  logic              ip_sync_reset,
   input  logic              ip_mdio_clk,
   inout  wire               io_mdio_data,
   output logic              op_mdio_oe,
   output logic [ADDR_W-1:0] op_reg_addr,
   output logic              op_reg_rd,
   input  logic [DATA_W-1:0] ip_reg_rdata,
   output logic              op_reg_wr,
   output logic [DATA_W-1:0] op_reg_wdata,
   output logic              op_busy
);

   localparam int                CNT_W   = $clog2(PREAMBLE_MIN + 1);
   localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PREAMBLE_MIN);

   // Input conditioning
   logic                   sample_evt;
   logic [SYNC_STAGES-1:0] mdio_sync_q;
   logic                   mdio_s;

   mdio_edge_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_mdc_sync (
      .clk_i  (ip_master_clk),
      .rst_i  (ip_sync_reset),
      .d_i    (ip_mdio_clk),
      .rise_o (sample_evt)
   );

   // MDIO only needs its level synchronized; it is qualified by the MDC edge.
   always_ff @(posedge ip_master_clk) begin
      if (ip_sync_reset) begin
         mdio_sync_q <= '1;
      end else begin
         mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], io_mdio_data};
      end
   end

   assign mdio_s = mdio_sync_q[SYNC_STAGES-1];

   // Frame state
   mdio_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        bit_q, bit_d;
   logic              is_rd_q, is_rd_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              rd_p1_q, rd_p1_d;
   logic              rd_p2_q, rd_p2_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              oe_q, oe_d;
   logic              dout_q, dout_d;

   logic [DATA_W-1:0] shift_in;
   logic [ADDR_W-1:0] field5;

   assign shift_in = {shreg_q[DATA_W-2:0], mdio_s};
   assign field5   = shift_in[ADDR_W-1:0];

   // Frame decoder: every field advances only on an MDC sample event; the
   // read-data capture runs on its own fixed delay after the read strobe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      is_rd_d = is_rd_q;
      shreg_d = shreg_q;
      addr_d  = addr_q;
      rd_d    = 1'b0;
      rd_p1_d = rd_q;
      rd_p2_d = rd_p1_q;
      wr_d    = 1'b0;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      oe_d    = oe_q;
      dout_d  = dout_q;

      // Local read data is valid two clocks after the strobe; TA is always
      // several system clocks later, so this never collides with a shift.
      if (rd_p2_q) begin
         shreg_d = ip_reg_rdata;
      end

      if (sample_evt) begin
         unique case (state_q)
            S_IDLE: begin
               if (mdio_s) begin
                  if (cnt_q < PRE_MAX) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if ((mdio_s == ST_CODE[1]) && (cnt_q >= PRE_MAX)) begin
                  state_d = S_ST1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = '0;
               end
            end

            S_ST1: begin
               if (mdio_s == ST_CODE[0]) begin
                  state_d = S_OP;
                  busy_d  = 1'b1;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end

            S_OP: begin
               shreg_d = shift_in;
               if (bit_q == 4'd1) begin
                  bit_d = '0;
                  if (op_is_valid(shift_in[1:0])) begin
                     state_d = S_PHYAD;
                     is_rd_d = (shift_in[1:0] == OP_READ);
                  end else begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                     busy_d  = 1'b0;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end

            S_PHYAD: begin
               shreg_d = shift_in;
               if (bit_q == 4'd4) begin
                  bit_d = '0;
                  if (field5 == PHY_ADDR) begin
                     state_d = S_REGAD;
                  end else begin
                     // Someone else's frame: drop out and ignore the rest.
                     state_d = S_IDLE;
                     cnt_d   = '0;
                     busy_d  = 1'b0;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end

            S_REGAD: begin
               shreg_d = shift_in;
               if (bit_q == 4'd4) begin
                  bit_d   = '0;
                  addr_d  = field5;
                  rd_d    = is_rd_q;
                  state_d = S_TA;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end

            S_TA: begin
               if (bit_q == 4'd0) begin
                  bit_d = 4'd1;
                  // Master samples Z on TA1; we pull low for TA2.
                  if (is_rd_q) begin
                     oe_d   = 1'b1;
                     dout_d = 1'b0;
                  end
               end else begin
                  bit_d   = '0;
                  state_d = S_DATA;
                  if (is_rd_q) begin
                     dout_d  = shreg_q[DATA_W-1];
                     shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                  end
               end
            end

            S_DATA: begin
               if (is_rd_q) begin
                  dout_d  = shreg_q[DATA_W-1];
                  shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
               end else begin
                  shreg_d = shift_in;
               end
               if (bit_q == 4'd15) begin
                  // Master has just sampled D0 (read) or sent it (write).
                  oe_d    = 1'b0;
                  state_d = S_IDLE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  bit_d   = '0;
                  if (!is_rd_q) begin
                     wdata_d = shift_in;
                     wr_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge ip_master_clk) begin
      if (ip_sync_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         is_rd_q <= 1'b0;
         shreg_q <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         rd_p1_q <= 1'b0;
         rd_p2_q <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         oe_q    <= 1'b0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         is_rd_q <= is_rd_d;
         shreg_q <= shreg_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         rd_p1_q <= rd_p1_d;
         rd_p2_q <= rd_p2_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         oe_q    <= oe_d;
         dout_q  <= dout_d;
      end
   end

   // Gating with reset releases the line in the very clock reset is raised.
   assign op_mdio_oe   = oe_q & ~ip_sync_reset;
   assign io_mdio_data = op_mdio_oe ? dout_q : 1'bz;

   assign op_reg_addr  = addr_q;
   assign op_reg_rd    = rd_q;
   assign op_reg_wr    = wr_q;
   assign op_reg_wdata = wdata_q;
   assign op_busy      = busy_q;

endmodule
